buzzer_arbiter: RTL and testbench

BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

---
 rtl/buzzer_arbiter.sv | 158 +++++++++++++++
 tb/tb_buzzer_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// Arbitrates one buzzer between the free, auto and learn note sources.
// A handover always passes through a muted gap before the new owner is heard.
`timescale 1ns/1ps

module buzzer_arbiter #(
    parameter int unsigned MUTE_CYCLES  = 1000000,
    parameter int unsigned IDLE_TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_sel,
    input  logic       req_free,
    input  logic       req_auto,
    input  logic       req_learn,
    input  logic [3:0] note_free,
    input  logic [3:0] note_auto,
    input  logic [3:0] note_learn,
    input  logic [1:0] oct_free,
    input  logic [1:0] oct_auto,
    input  logic [1:0] oct_learn,
    output logic [3:0] note_to_play,
    output logic [1:0] octave_out,
    output logic [2:0] grant,
    output logic       muted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWITCH,
        S_ACTIVE
    } state_e;

    localparam logic [23:0] MUTE_LAST   = 24'(MUTE_CYCLES - 1);
    localparam logic [25:0] SILENCE_MAX = 26'(IDLE_TIMEOUT);
    localparam logic [3:0]  END_MARK    = 4'hF;

    state_e      state_q;
    logic [1:0]  target_q;
    logic [23:0] mute_cnt_q;
    logic [25:0] silence_q;
    logic [3:0]  note_q;
    logic [1:0]  oct_q;
    logic [2:0]  grant_q;
    logic        muted_q;

    logic       owner_req;
    logic [3:0] owner_note;
    logic [1:0] owner_oct;

    function automatic logic [2:0] owner_onehot(input logic [1:0] sel);
        case (sel)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // NOTE: every signal gets a default first so this mux can never infer a latch.
    always_comb begin
        owner_req  = 1'b0;
        owner_note = 4'd0;
        owner_oct  = 2'd0;
        case (target_q)
            2'b01: begin owner_req = req_free;  owner_note = note_free;  owner_oct = oct_free;  end
            2'b10: begin owner_req = req_auto;  owner_note = note_auto;  owner_oct = oct_auto;  end
            2'b11: begin owner_req = req_learn; owner_note = note_learn; owner_oct = oct_learn; end
            default: ;
        endcase
    end

    // NOTE: state and outputs update with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            target_q   <= 2'b00;
            mute_cnt_q <= '0;
            silence_q  <= '0;
            note_q     <= '0;
            oct_q      <= '0;
            grant_q    <= '0;
            muted_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode_sel != 2'b00) begin
                        state_q    <= S_SWITCH;
                        target_q   <= mode_sel;
                        mute_cnt_q <= '0;
                        muted_q    <= 1'b1;
                    end
                end

                S_SWITCH: begin
                    if (mode_sel == 2'b00) begin
                        state_q    <= S_IDLE;
                        mute_cnt_q <= '0;
                        muted_q    <= 1'b0;
                    end else if (mode_sel != target_q) begin
                        // A new request mid-gap restarts the full silence window.
                        target_q   <= mode_sel;
                        mute_cnt_q <= '0;
                    end else if (mute_cnt_q == MUTE_LAST) begin
                        state_q   <= S_ACTIVE;
                        grant_q   <= owner_onehot(target_q);
                        silence_q <= '0;
                        muted_q   <= 1'b0;
                    end else begin
                        mute_cnt_q <= mute_cnt_q + 24'd1;
                    end
                end

                S_ACTIVE: begin
                    if (mode_sel != target_q) begin
                        // Losing ownership wins over a same-cycle note from the old owner.
                        grant_q   <= '0;
                        note_q    <= '0;
                        oct_q     <= '0;
                        silence_q <= '0;
                        if (mode_sel == 2'b00) begin
                            state_q <= S_IDLE;
                            muted_q <= 1'b0;
                        end else begin
                            state_q    <= S_SWITCH;
                            target_q   <= mode_sel;
                            mute_cnt_q <= '0;
                            muted_q    <= 1'b1;
                        end
                    end else if (owner_req) begin
                        note_q    <= (owner_note == END_MARK) ? 4'd0 : owner_note;
                        oct_q     <= owner_oct;
                        silence_q <= '0;
                        muted_q   <= 1'b0;
                    end else begin
                        note_q <= '0;
                        if (silence_q != SILENCE_MAX) begin
                            silence_q <= silence_q + 26'd1;
                        end else begin
                            muted_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    muted_q <= 1'b0;
                end
            endcase
        end
    end

    assign note_to_play = note_q;
    assign octave_out   = oct_q;
    assign grant        = grant_q;
    assign muted        = muted_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter with MUTE_CYCLES=4 and IDLE_TIMEOUT=8.
// Stimulus queues the hand-computed post-edge outputs; a monitor pops and compares.
`timescale 1ns/1ps

module tb_buzzer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_sel;
    logic       req_free, req_auto, req_learn;
    logic [3:0] note_free, note_auto, note_learn;
    logic [1:0] oct_free, oct_auto, oct_learn;
    logic [3:0] note_to_play;
    logic [1:0] octave_out;
    logic [2:0] grant;
    logic       muted;

    typedef struct {
        string      tag;
        logic [2:0] g;
        logic [3:0] n;
        logic [1:0] o;
        logic       m;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    buzzer_arbiter #(
        .MUTE_CYCLES (4),
        .IDLE_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_sel    (mode_sel),
        .req_free    (req_free),
        .req_auto    (req_auto),
        .req_learn   (req_learn),
        .note_free   (note_free),
        .note_auto   (note_auto),
        .note_learn  (note_learn),
        .oct_free    (oct_free),
        .oct_auto    (oct_auto),
        .oct_learn   (oct_learn),
        .note_to_play(note_to_play),
        .octave_out  (octave_out),
        .grant       (grant),
        .muted       (muted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the expected post-edge outputs, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [2:0] g, input logic [3:0] n,
                       input logic [1:0] o, input logic m);
        exp_t e;
        e.tag = tag; e.g = g; e.n = n; e.o = o; e.m = m;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"}, 8'(grant),        8'd0);
        check({tag, ".note"},  8'(note_to_play), 8'd0);
        check({tag, ".oct"},   8'(octave_out),   8'd0);
        check({tag, ".muted"}, 8'(muted),        8'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".grant"}, 8'(grant),        8'(e.g));
                check({e.tag, ".note"},  8'(note_to_play), 8'(e.n));
                check({e.tag, ".oct"},   8'(octave_out),   8'(e.o));
                check({e.tag, ".muted"}, 8'(muted),        8'(e.m));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stimulus
        reset    = 1'b0;
        mode_sel = 2'b00;
        req_free = 1'b0; req_auto = 1'b0; req_learn = 1'b0;
        note_free = 4'd0; note_auto = 4'd0; note_learn = 4'd0;
        oct_free = 2'd0; oct_auto = 2'd0; oct_learn = 2'd0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        cyc("idle", 3'b000, 4'd0, 2'd0, 1'b0);

        // Startup: auto requests with note 3 / octave 2.
        mode_sel = 2'b10; req_auto = 1'b1; note_auto = 4'd3; oct_auto = 2'd2;
        for (int i = 0; i < 4; i++) cyc("start_gap", 3'b000, 4'd0, 2'd0, 1'b1);
        cyc("start_grant", 3'b010, 4'd0, 2'd0, 1'b0);
        cyc("start_note", 3'b010, 4'd3, 2'd2, 1'b0);

        // Non-owner isolation.
        req_free = 1'b1; note_free = 4'd5; oct_free = 2'd1;
        cyc("iso_a", 3'b010, 4'd3, 2'd2, 1'b0);
        cyc("iso_b", 3'b010, 4'd3, 2'd2, 1'b0);
        note_auto = 4'd7; oct_auto = 2'd1;
        cyc("iso_owner", 3'b010, 4'd7, 2'd1, 1'b0);
        req_free = 1'b0;

        // End marker, then idle timeout with octave held.
        note_auto = 4'hF; oct_auto = 2'd3;
        cyc("end_mark", 3'b010, 4'd0, 2'd3, 1'b0);
        req_auto = 1'b0; note_auto = 4'd6; oct_auto = 2'd0;
        for (int i = 0; i < 8; i++) cyc("silent", 3'b010, 4'd0, 2'd3, 1'b0);
        cyc("timeout", 3'b010, 4'd0, 2'd3, 1'b1);
        cyc("timeout_hold", 3'b010, 4'd0, 2'd3, 1'b1);
        req_auto = 1'b1; oct_auto = 2'd1;
        cyc("wake", 3'b010, 4'd6, 2'd1, 1'b0);

        // Release to idle in the same cycle as an owner note.
        mode_sel = 2'b00; note_auto = 4'd2; oct_auto = 2'd2;
        cyc("release", 3'b000, 4'd0, 2'd0, 1'b0);
        cyc("release_idle", 3'b000, 4'd0, 2'd0, 1'b0);
        req_auto = 1'b0;

        // Retarget from free to learn at mute count 2.
        mode_sel = 2'b01; req_free = 1'b1; note_free = 4'd4; oct_free = 2'd1;
        for (int i = 0; i < 3; i++) cyc("gap_free", 3'b000, 4'd0, 2'd0, 1'b1);
        mode_sel = 2'b11; req_learn = 1'b1; note_learn = 4'd5; oct_learn = 2'd2;
        for (int i = 0; i < 4; i++) cyc("gap_learn", 3'b000, 4'd0, 2'd0, 1'b1);
        cyc("learn_grant", 3'b100, 4'd0, 2'd0, 1'b0);
        cyc("learn_note", 3'b100, 4'd5, 2'd2, 1'b0);

        // Direct ACTIVE-to-SWITCH handover from learn to auto.
        mode_sel = 2'b10; req_auto = 1'b1; note_auto = 4'd1; oct_auto = 2'd1;
        for (int i = 0; i < 4; i++) cyc("gap_auto", 3'b000, 4'd0, 2'd0, 1'b1);
        cyc("auto_grant", 3'b010, 4'd0, 2'd0, 1'b0);
        cyc("auto_note", 3'b010, 4'd1, 2'd1, 1'b0);

        // Asynchronous reset between clock edges while ACTIVE.
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b1; mode_sel = 2'b00;
        cyc("post_rst", 3'b000, 4'd0, 2'd0, 1'b0);

        // Reset mid-handover restarts the full gap from IDLE.
        mode_sel = 2'b01;
        cyc("pre_rst_gap0", 3'b000, 4'd0, 2'd0, 1'b1);
        cyc("pre_rst_gap1", 3'b000, 4'd0, 2'd0, 1'b1);
        #2 reset = 1'b0;
        #1 check_all_zero("handover_rst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc("regap", 3'b000, 4'd0, 2'd0, 1'b1);
        cyc("free_grant", 3'b001, 4'd0, 2'd0, 1'b0);
        cyc("free_note", 3'b001, 4'd4, 2'd1, 1'b0);

        mode_sel = 2'b00;
        cyc("final_idle", 3'b000, 4'd0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
